// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality check used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B        = 3'b000;
  localparam logic [2:0] F3_H        = 3'b001;
  localparam logic [2:0] F3_W        = 3'b010;
  localparam logic [2:0] F3_BU       = 3'b100;
  localparam logic [2:0] F3_HU       = 3'b101;
  localparam logic [2:0] MEM_WORD_F3 = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WRITE,
    RESP
  } lsu_state_t;

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic illegal;
    logic misal;
    if (we) illegal = (f3 > F3_W);
    else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misal = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
            ((f3 == F3_W) && (off != 2'b00));
    return illegal || misal;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extends the addressed lane(s) of a memory word for loads
// and splices store data into the word for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {i_offset, 3'b000};
  assign w_half_sh = {i_offset[1], 4'b0000};
  assign w_byte    = i_word[w_byte_sh +: 8];
  assign w_half    = i_word[w_half_sh +: 16];

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_word;
      F3_BU:   o_load_data = {24'b0, w_byte};
      F3_HU:   o_load_data = {16'b0, w_half};
      default: o_load_data = '0;
    endcase
  end

  // Lanes outside the store width keep the value just read from memory.
  always_comb begin
    o_merged = i_store_data;
    case (i_funct3)
      F3_B: o_merged = (i_word & ~(32'h0000_00FF << w_byte_sh)) |
                       ({24'b0, i_store_data[7:0]} << w_byte_sh);
      F3_H: o_merged = (i_word & ~(32'h0000_FFFF << w_half_sh)) |
                       ({16'b0, i_store_data[15:0]} << w_half_sh);
      default: o_merged = i_store_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-only data memory: one request at a time,
// lane extraction for loads, read-modify-write for byte/halfword stores.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t            r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_offset;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DM_ADDRESS-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     w_merged;

  lsu_lane_align u_align (
    .i_word       (mem_rdata),
    .i_offset     (r_offset),
    .i_funct3     (r_funct3),
    .i_store_data (r_wdata),
    .o_load_data  (w_load_data),
    .o_merged     (w_merged)
  );

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_funct3 = MEM_WORD_F3;

  // Every output is registered alongside the state it belongs to, so a state
  // change and its strobes appear together one edge after the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_offset    <= req_addr[1:0];
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_mem_addr  <= {req_addr[DM_ADDRESS-1:2], 2'b00};
            if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_state     <= WRITE;
              r_mem_write <= 1'b1;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state    <= RD_ISSUE;
              r_mem_read <= 1'b1;
            end
          end
        end
        RD_ISSUE: r_state <= RD_CAPTURE;
        RD_CAPTURE: begin
          r_mem_read <= 1'b0;
          if (r_we) begin
            r_state     <= WRITE;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_data;
          end
        end
        WRITE: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a transaction-level model predicts each request's
// timeline and data; a per-cycle process compares the DUT against it.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram  [0:127];
  logic [31:0] gold [0:127];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int          tAccept   = -1000;
  int          tLat      = 0;
  int          tWriteRel = -1;
  bit          tReads    = 0;
  logic [31:0] tRd       = '0;
  logic [31:0] tWData    = '0;
  logic        tErr      = 1'b0;
  logic [8:0]  tAddr     = '0;
  bit          trackOn   = 0;
  logic [31:0] lastRsp, lastWData;
  logic        lastErr;
  bit          sawWrite  = 0;

  lsu_mem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous word memory: read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= ram[mem_addr[8:2]];
    if (mem_write) ram[mem_addr[8:2]] <= mem_wdata;
  end

  always @(posedge mem_write) sawWrite = 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Predict one request from size/alignment rules and the golden memory.
  task automatic modelTxn(input logic we, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wd);
    int          w, off, nBytes;
    bit          legal;
    logic [31:0] v;
    w      = int'(addr[8:2]);
    off    = int'(addr[1:0]);
    nBytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    tAddr = {addr[8:2], 2'b00};
    tErr = 1'b0; tRd = '0; tReads = 0; tWriteRel = -1; tWData = '0;
    if (!legal || (off % nBytes) != 0) begin
      tErr = 1'b1;
      tLat = 1;
    end else if (!we) begin
      tLat = 3;
      tReads = 1;
      v = gold[w] >> (8 * off);
      if (nBytes < 4) begin
        v = v & ~(32'hFFFF_FFFF << (8 * nBytes));
        if (!f3[2] && v[8*nBytes-1]) v = v | (32'hFFFF_FFFF << (8 * nBytes));
      end
      tRd = v;
    end else begin
      v = gold[w];
      for (int i = 0; i < nBytes; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
      gold[w] = v;
      tWData  = v;
      if (nBytes == 4) begin
        tLat = 2; tWriteRel = 1;
      end else begin
        tLat = 4; tWriteRel = 3; tReads = 1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the current prediction.
  always @(negedge clk) begin : cmpProc
    int rel;
    bit expRd, expWr;
    if (trackOn && rst_n) begin
      rel   = cyc - tAccept;
      expRd = tReads && (rel == 1 || rel == 2);
      expWr = (rel == tWriteRel);
      checkOutput("req_ready", 32'(req_ready), 32'(rel > tLat));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(rel == tLat));
      if (rel == tLat) begin
        checkOutput("rsp_err", 32'(rsp_err), 32'(tErr));
        checkOutput("rsp_rdata", rsp_rdata, tRd);
        lastRsp = rsp_rdata;
        lastErr = rsp_err;
      end
      checkOutput("mem_read", 32'(mem_read), 32'(expRd));
      checkOutput("mem_write", 32'(mem_write), 32'(expWr));
      if (expRd || expWr) checkOutput("mem_addr", 32'(mem_addr), 32'(tAddr));
      if (expWr) begin
        checkOutput("mem_wdata", mem_wdata, tWData);
        lastWData = mem_wdata;
      end
      checkOutput("strobe_excl", 32'(mem_read & mem_write), 32'h0);
      checkOutput("mem_funct3", 32'(mem_funct3), 32'h2);
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [8:0] addr, input logic [31:0] wd,
                               input logic [31:0] litRd, input logic litErr);
    lastRsp = 32'hBAD0_BAD0;
    lastErr = ~litErr;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr;  req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tAccept = cyc - 1;
    modelTxn(we, f3, addr, wd);
    repeat (tLat + 1) @(negedge clk);
    #1;
    checkOutput("lit_rdata", lastRsp, litRd);
    checkOutput("lit_err", 32'(lastErr), 32'(litErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    ram[0] = 32'h8899_AABB;
    ram[4] = 32'h1122_3344;
    ram[5] = 32'h5566_7788;
    for (int i = 0; i < 128; i++) gold[i] = ram[i];

    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'h0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    trackOn = 1;

    applyStimulus(1'b0, 3'b000, 9'h001, 32'h0, 32'hFFFF_FFAA, 1'b0);
    applyStimulus(1'b0, 3'b100, 9'h003, 32'h0, 32'h0000_0088, 1'b0);
    applyStimulus(1'b0, 3'b001, 9'h002, 32'h0, 32'hFFFF_8899, 1'b0);
    applyStimulus(1'b0, 3'b101, 9'h000, 32'h0, 32'h0000_AABB, 1'b0);
    applyStimulus(1'b0, 3'b010, 9'h000, 32'h0, 32'h8899_AABB, 1'b0);
    applyStimulus(1'b0, 3'b000, 9'h000, 32'h0, 32'hFFFF_FFBB, 1'b0);
    applyStimulus(1'b0, 3'b100, 9'h002, 32'h0, 32'h0000_0099, 1'b0);

    lastWData = 32'hBAD0_BAD0;
    applyStimulus(1'b1, 3'b000, 9'h012, 32'h0000_00EE, 32'h0, 1'b0);
    checkOutput("lit_sb_wdata", lastWData, 32'h11EE_3344);
    applyStimulus(1'b0, 3'b010, 9'h010, 32'h0, 32'h11EE_3344, 1'b0);
    applyStimulus(1'b0, 3'b000, 9'h013, 32'h0, 32'h0000_0011, 1'b0);

    lastWData = 32'hBAD0_BAD0;
    applyStimulus(1'b1, 3'b010, 9'h020, 32'hDEAD_BEEF, 32'h0, 1'b0);
    checkOutput("lit_sw_wdata", lastWData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b010, 9'h020, 32'h0, 32'hDEAD_BEEF, 1'b0);

    lastWData = 32'hBAD0_BAD0;
    applyStimulus(1'b1, 3'b001, 9'h016, 32'h0000_CAFE, 32'h0, 1'b0);
    checkOutput("lit_sh_wdata", lastWData, 32'hCAFE_7788);
    applyStimulus(1'b0, 3'b101, 9'h016, 32'h0, 32'h0000_CAFE, 1'b0);
    applyStimulus(1'b0, 3'b001, 9'h016, 32'h0, 32'hFFFF_CAFE, 1'b0);

    applyStimulus(1'b0, 3'b010, 9'h006, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b001, 9'h003, 32'h1234, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b011, 9'h000, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b100, 9'h000, 32'h55, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b101, 9'h001, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b110, 9'h004, 32'h0, 32'h0, 1'b1);

    // Reset during the capture cycle of an SH must abandon the write.
    trackOn = 0;
    sawWrite = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 9'h012; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_capture_rd", 32'(mem_read), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_read", 32'(mem_read), 32'h0);
    checkOutput("abort_mem_write", 32'(mem_write), 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_write", 32'(sawWrite), 32'h0);
    checkOutput("abort_word", ram[4], gold[4]);
    checkOutput("abort_ready_after", 32'(req_ready), 32'h1);
    tAccept = cyc - 1000; tLat = 0; tWriteRel = -1; tReads = 0;
    trackOn = 1;
    applyStimulus(1'b0, 3'b010, 9'h010, 32'h0, 32'h11EE_3344, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
